bit_collect: RTL and testbench
==============================

Name: bit_collect

Overview:
- Serial-to-parallel assembler on the decode path: accepts one bit per valid/ready handshake and assembles WIDTH-bit words.
- Bit k of a word is written to output position k, so the word round-trips with the per-bit selector used on the transmit side.
- Holds one completed word in an output register with its own valid/ready handshake, so the next word can assemble while the previous one waits.

Parameters:
- WIDTH, 8, number of bits per assembled word (>=2).
- LSB_FIRST, 1, 1: first received bit lands in byte_out[0]; 0: first bit lands in byte_out[WIDTH-1].

Ports:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- frame_start  in  1  pulse; discards any partial word.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block accepts bit_in this cycle.
- bit_n  out  clog2(WIDTH)  index of the next bit to be written (0..WIDTH-1).
- byte_out  out  WIDTH  completed word.
- byte_valid  out  1  byte_out holds an unconsumed word.
- byte_ready  in  1  downstream consumes byte_out when byte_valid=1.

Behaviour:
- Reset (one clk with rst=1): cnt=0, assembly register=0, byte_out=0, byte_valid=0.
  - bit_ready is 1 after reset, since it is combinational and byte_valid=0.
  - rst overrides every other input, including mid-word and with byte_valid=1; the pending word is lost.
- bit_n = cnt (registered counter).
- Bit acceptance: accept = bit_valid && bit_ready.
- bit_ready = (cnt != WIDTH-1) || !byte_valid || byte_ready.
  - Only the final bit of a word can stall.
  - bit_ready is combinational from byte_ready. No other combinational input-to-output paths are allowed.
- Accepted bit with cnt < WIDTH-1:
  - Write the bit to assembly position p, where p = cnt if LSB_FIRST=1, else WIDTH-1-cnt.
  - cnt <= cnt+1.
- Accepted bit with cnt == WIDTH-1 (word complete):
  - byte_out <= assembly register with the final bit merged at position p.
  - byte_valid <= 1; cnt <= 0; assembly register <= 0.
- Latency: byte_valid rises the cycle after the last bit is accepted.
- Sustained throughput is WIDTH bits in WIDTH cycles when byte_ready=1 throughout.
- Output handshake:
  - A word is consumed when byte_valid && byte_ready. byte_valid then clears next cycle unless a new word completes in the same cycle.
  - Consume and complete in the same cycle: byte_out is replaced and byte_valid stays 1 (no bubble).
  - byte_out holds its value while byte_valid=1 and byte_ready=0.
  - byte_out keeps its last value after consumption.
- frame_start:
  - cnt <= 0 and the assembly register is cleared. byte_out and byte_valid are unaffected.
  - frame_start with an accepted bit in the same cycle: the bit is taken as bit 0 of the new word, and cnt becomes 1.
- Bits presented with bit_valid=0 are ignored. bit_in is don't-care when bit_valid=0.
- cnt never exceeds WIDTH-1 and wraps only through word completion.

Decomposition:
- Shared package (de_coder_pkg):
  - constant DEFAULT_WIDTH=8.
  - function clog2 for the bit_n width.
  - typedef for the bit-index type, shared with the transmit-side selector.
- No sub-module required.
- Optional: bit_insert, a combinational position-decode writer for the assembly register, if reuse is wanted.

Test Plan:
- Reset, then bits 1,0,1,0,1,1,0,0 on consecutive cycles, byte_ready=1, LSB_FIRST=1 -> byte_out=0x35 and byte_valid=1 exactly one cycle after the 8th bit; bit_n steps 0..7 then 0.
- Same bit sequence with LSB_FIRST=0 -> byte_out=0xAC.
- Backpressure: byte_ready=0 after first word 0x35, stream second word 0xC3 -> bits 0..6 accepted, bit_ready=0 at cnt=7 until byte_ready=1. Then 0x35 is consumed and 0xC3 loads in the same cycle with byte_valid continuously 1.
- Back-to-back: 32 bits forming 0x01,0x80,0xFF,0x00 with byte_ready=1 -> four words, each valid for one cycle, spaced 8 cycles apart, bit_ready never 0.
- frame_start after 3 bits, then 8 bits of 0x5A -> output 0x5A only; the partial word is never emitted. frame_start coincident with a valid bit -> that bit becomes bit 0.
- rst asserted at cnt=5 while byte_valid=1 -> next cycle cnt=0, byte_valid=0, byte_out=0. The following 8 bits assemble a correct word.

Source files
------------

// File: rtl/de_coder_pkg.sv
// Shared definitions for the serial decode path: default word width,
// index-width helper and the bit-index type used by both the transmit-side
// selector and the receive-side collector.
package de_coder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Ceiling log2, never less than 1 so a one-bit index still has a port.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [clog2(DEFAULT_WIDTH)-1:0] bit_idx_t;

endpackage

// File: rtl/bit_collect.sv
// Serial-to-parallel word assembler. One bit per bit_valid/bit_ready handshake
// is written into an assembly register; a completed word moves into a
// one-deep output register with its own byte_valid/byte_ready handshake, so
// the next word can assemble while the previous one waits downstream.
module bit_collect
    import de_coder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic [clog2(WIDTH)-1:0] bit_n,
    output logic [WIDTH-1:0]        byte_out,
    output logic                    byte_valid,
    input  logic                    byte_ready
);

    localparam int              CW   = clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_byte_out;
    logic             r_byte_valid;

    logic             w_accept;
    logic             w_complete;
    logic             w_consume;
    logic [CW-1:0]    w_cnt_eff;
    logic [CW-1:0]    w_pos;
    logic [WIDTH-1:0] w_asm_base;
    logic [WIDTH-1:0] w_asm_next;

    // Only the last bit of a word can stall: it needs room in the output register.
    assign bit_ready  = (r_cnt != LAST) || !r_byte_valid || byte_ready;
    assign w_accept   = bit_valid && bit_ready;
    assign w_consume  = r_byte_valid && byte_ready;

    // frame_start restarts the word in the same cycle, so a coincident bit
    // lands as bit 0 of a fresh (cleared) word instead of the stale position.
    assign w_cnt_eff  = frame_start ? '0 : r_cnt;
    assign w_asm_base = frame_start ? '0 : r_asm;
    assign w_pos      = LSB_FIRST ? w_cnt_eff : (LAST - w_cnt_eff);
    assign w_complete = w_accept && (w_cnt_eff == LAST);

    // Merge the incoming bit into its decoded position of the assembly word.
    always_comb begin
        w_asm_next        = w_asm_base;
        w_asm_next[w_pos] = bit_in;
    end

    // Bit counter, assembly register and output register with handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_asm        <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            if (frame_start) begin
                r_cnt <= '0;
                r_asm <= '0;
            end
            if (w_accept) begin
                if (w_complete) begin
                    r_byte_out <= w_asm_next;
                    r_cnt      <= '0;
                    r_asm      <= '0;
                end else begin
                    r_asm <= w_asm_next;
                    r_cnt <= w_cnt_eff + CW'(1);
                end
            end
            // A completing word refills the output register in the same cycle
            // the previous one is consumed, so byte_valid has no bubble.
            if (w_complete) begin
                r_byte_valid <= 1'b1;
            end else if (w_consume) begin
                r_byte_valid <= 1'b0;
            end
        end
    end

    assign bit_n      = r_cnt;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;

endmodule

// File: tb/tb_bit_collect.sv
// Self-checking bench for bit_collect: one LSB-first and one MSB-first
// instance share the same stimulus and are compared against a queue-based
// model of the word assembly and output handshake.
module tb_bit_collect;
    import de_coder_pkg::*;

    localparam int W  = 8;
    localparam int CW = clog2(W);

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          bit_in;
    logic          bit_valid;
    logic          byte_ready;
    logic          rdy_l, rdy_m;
    logic [CW-1:0] n_l, n_m;
    logic [W-1:0]  out_l, out_m;
    logic          val_l, val_m;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic     mq[$];
    logic [W-1:0] m_out_l = '0;
    logic [W-1:0] m_out_m = '0;
    logic     m_valid = 1'b0;
    logic     m_rdy;
    logic     obs_rdy_l, obs_rdy_m;

    bit_collect #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(rdy_l), .bit_n(n_l),
        .byte_out(out_l), .byte_valid(val_l), .byte_ready(byte_ready));

    bit_collect #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(rdy_m), .bit_n(n_m),
        .byte_out(out_m), .byte_valid(val_m), .byte_ready(byte_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    // One clock cycle: drive inputs in the low phase, sample bit_ready,
    // advance the model on the rising edge and return at the falling edge.
    task automatic cyc(input logic fs, input logic bv, input logic bi,
                       input logic br, input logic rs);
        logic         consumed;
        logic         completed;
        logic [W-1:0] wl, wm;
        frame_start = fs;
        bit_valid   = bv;
        bit_in      = bi;
        byte_ready  = br;
        rst         = rs;
        #1;
        m_rdy     = !((mq.size() == W-1) && m_valid && !br);
        obs_rdy_l = rdy_l;
        obs_rdy_m = rdy_m;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_valid = 1'b0;
            m_out_l = '0;
            m_out_m = '0;
        end else begin
            consumed  = m_valid && br;
            completed = 1'b0;
            if (fs) mq.delete();
            if (bv && m_rdy) begin
                mq.push_back(bi);
                if (mq.size() == W) begin
                    wl = '0;
                    wm = '0;
                    for (int k = 0; k < W; k++) begin
                        wl[k]       = mq[k];
                        wm[W-1-k]   = mq[k];
                    end
                    m_out_l   = wl;
                    m_out_m   = wm;
                    m_valid   = 1'b1;
                    completed = 1'b1;
                    mq.delete();
                end
            end
            if (!completed && consumed) m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        n_checks++;
        if (n_l !== '0 || n_m !== '0) begin
            n_fail++;
            $display("FAIL reset_bit_n: got %0d/%0d, expected 0", n_l, n_m);
        end
        n_checks++;
        if (val_l !== 1'b0 || val_m !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_byte_valid: got %b/%b, expected 0", val_l, val_m);
        end
        n_checks++;
        if (out_l !== '0 || out_m !== '0) begin
            n_fail++;
            $display("FAIL reset_byte_out: got %h/%h, expected 00", out_l, out_m);
        end
        n_checks++;
        if (obs_rdy_l !== 1'b1 || obs_rdy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_bit_ready: got %b/%b, expected 1", obs_rdy_l, obs_rdy_m);
        end
    endtask

    task automatic test_basic_word();
        logic seq[8] = '{1, 0, 1, 0, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (n_l !== CW'(i) || n_m !== CW'(i)) begin
                n_fail++;
                $display("FAIL basic_bit_n[%0d]: got %0d/%0d, expected %0d", i, n_l, n_m, i);
            end
            cyc(0, 1, seq[i], 1, 0);
            n_checks++;
            if (val_l !== (i == 7) || val_m !== (i == 7)) begin
                n_fail++;
                $display("FAIL basic_valid_timing[%0d]: got %b/%b, expected %b", i, val_l, val_m, i == 7);
            end
        end
        n_checks++;
        if (out_l !== 8'h35) begin
            n_fail++;
            $display("FAIL basic_lsb_word: got %h, expected 35", out_l);
        end
        n_checks++;
        if (out_m !== 8'hAC) begin
            n_fail++;
            $display("FAIL basic_msb_word: got %h, expected ac", out_m);
        end
        n_checks++;
        if (n_l !== '0) begin
            n_fail++;
            $display("FAIL basic_bit_n_wrap: got %0d, expected 0", n_l);
        end
        cyc(0, 0, 0, 1, 0);
        n_checks++;
        if (val_l !== 1'b0 || out_l !== 8'h35) begin
            n_fail++;
            $display("FAIL basic_consume: got valid %b out %h, expected 0 / 35", val_l, out_l);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w2 = 8'hC3;
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'h35 >> i, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, w2[i], 0, 0);
            n_checks++;
            if (obs_rdy_l !== 1'b1 || n_l !== CW'(i + 1)) begin
                n_fail++;
                $display("FAIL bp_accept[%0d]: got rdy %b cnt %0d, expected 1 / %0d", i, obs_rdy_l, n_l, i + 1);
            end
        end
        for (int s = 0; s < 3; s++) begin
            cyc(0, 1, w2[7], 0, 0);
            n_checks++;
            if (obs_rdy_l !== 1'b0 || obs_rdy_m !== 1'b0 || n_l !== CW'(7)) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got rdy %b/%b cnt %0d, expected 0 / 7", s, obs_rdy_l, obs_rdy_m, n_l);
            end
            n_checks++;
            if (val_l !== 1'b1 || out_l !== 8'h35) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid %b out %h, expected 1 / 35", s, val_l, out_l);
            end
        end
        cyc(0, 1, w2[7], 1, 0);
        n_checks++;
        if (obs_rdy_l !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b, expected 1", obs_rdy_l);
        end
        n_checks++;
        if (val_l !== 1'b1 || out_l !== 8'hC3 || out_m !== m_out_m) begin
            n_fail++;
            $display("FAIL bp_swap: got valid %b out %h/%h, expected 1 / c3/%h", val_l, out_l, out_m, m_out_m);
        end
        cyc(0, 0, 0, 1, 0);
        n_checks++;
        if (val_l !== 1'b0 || n_l !== '0) begin
            n_fail++;
            $display("FAIL bp_drain: got valid %b cnt %0d, expected 0 / 0", val_l, n_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
        logic [7:0] wv;
        int seen = 0;
        for (int i = 0; i < 32; i++) begin
            wv = words[i / 8];
            cyc(0, 1, wv[i % 8], 1, 0);
            n_checks++;
            if (obs_rdy_l !== 1'b1 || val_l !== ((i % 8) == 7)) begin
                n_fail++;
                $display("FAIL b2b_cycle[%0d]: got rdy %b valid %b, expected 1 / %b", i, obs_rdy_l, val_l, (i % 8) == 7);
            end
            if ((i % 8) == 7) begin
                seen++;
                n_checks++;
                if (out_l !== wv || out_m !== m_out_m) begin
                    n_fail++;
                    $display("FAIL b2b_word[%0d]: got %h/%h, expected %h/%h", i / 8, out_l, out_m, wv, m_out_m);
                end
            end
        end
        cyc(0, 0, 0, 1, 0);
        n_checks++;
        if (seen != 4 || val_l !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words valid %b, expected 4 / 0", seen, val_l);
        end
    endtask

    task automatic test_frame_start();
        logic [7:0] w = 8'h5A;
        for (int i = 0; i < 3; i++) cyc(0, 1, $urandom_range(0, 1), 1, 0);
        cyc(1, 0, 0, 1, 0);
        n_checks++;
        if (n_l !== '0 || val_l !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_clear: got cnt %0d valid %b, expected 0 / 0", n_l, val_l);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, w[i], 1, 0);
            if (i < 7) begin
                n_checks++;
                if (val_l !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fs_no_partial[%0d]: got valid 1, expected 0", i);
                end
            end
        end
        n_checks++;
        if (val_l !== 1'b1 || out_l !== 8'h5A || out_m !== m_out_m) begin
            n_fail++;
            $display("FAIL fs_word: got valid %b out %h/%h, expected 1 / 5a/%h", val_l, out_l, out_m, m_out_m);
        end
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(1, 1, 1, 1, 0);
        n_checks++;
        if (n_l !== CW'(1) || n_m !== CW'(1)) begin
            n_fail++;
            $display("FAIL fs_coincident_cnt: got %0d/%0d, expected 1", n_l, n_m);
        end
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 1, 0);
        n_checks++;
        if (val_l !== 1'b1 || out_l !== 8'h01 || out_m !== 8'h80) begin
            n_fail++;
            $display("FAIL fs_coincident_word: got valid %b out %h/%h, expected 1 / 01/80", val_l, out_l, out_m);
        end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        n_checks++;
        if (n_l !== CW'(5) || val_l !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: got cnt %0d valid %b, expected 5 / 1", n_l, val_l);
        end
        cyc(0, 1, 1, 0, 1);
        n_checks++;
        if (n_l !== '0 || val_l !== 1'b0 || out_l !== '0 || out_m !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got cnt %0d valid %b out %h/%h, expected 0 / 0 / 00", n_l, val_l, out_l, out_m);
        end
        w = 8'($urandom);
        for (int i = 0; i < 8; i++) cyc(0, 1, w[i], 1, 0);
        n_checks++;
        if (val_l !== 1'b1 || out_l !== w || out_m !== m_out_m) begin
            n_fail++;
            $display("FAIL rstmid_word: got valid %b out %h/%h, expected 1 / %h/%h", val_l, out_l, out_m, w, m_out_m);
        end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic fs, bv, bi, br;
        for (int i = 0; i < 400; i++) begin
            fs = ($urandom_range(0, 15) == 0);
            bv = ($urandom_range(0, 3) != 0);
            bi = $urandom_range(0, 1);
            br = ($urandom_range(0, 2) != 0);
            cyc(fs, bv, bi, br, 0);
            n_checks++;
            if (obs_rdy_l !== m_rdy || obs_rdy_m !== m_rdy) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b/%b, expected %b", i, obs_rdy_l, obs_rdy_m, m_rdy);
            end
            n_checks++;
            if (n_l !== CW'(mq.size()) || n_m !== CW'(mq.size())) begin
                n_fail++;
                $display("FAIL rand_bit_n[%0d]: got %0d/%0d, expected %0d", i, n_l, n_m, mq.size());
            end
            n_checks++;
            if (val_l !== m_valid || val_m !== m_valid ||
                out_l !== m_out_l || out_m !== m_out_m) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got valid %b/%b out %h/%h, expected %b out %h/%h",
                         i, val_l, val_m, out_l, out_m, m_valid, m_out_l, m_out_m);
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; byte_ready = 1'b0;
        test_reset();
        test_basic_word();
        test_backpressure();
        test_back_to_back();
        test_frame_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
